dm_be: RTL

Parametrised data memory for the MIPS32 datapath. It supports byte, halfword and word loads and stores with sign or zero extension, and raises a fault on misaligned access. Synchronous reset starts a multi-cycle clear sweep, during which the block holds `busy` so the core can stall. It sits in the MEM stage, directly replacing the fixed word-only data memory.

---
 rtl/dm_be_if.sv | 24 ++
 rtl/dm_be.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dm_be_if.sv
// Bus between the MIPS32 MEM stage and the byte-enabled data memory.
// The core is master; the memory is slave.
interface dm_be_if;
  logic [31:0] addr;
  logic [31:0] invalue;
  logic        memwrite;
  logic        memread;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] outvalue;
  logic        busy;
  logic        fault;
  logic        dbg_state;

  modport master (
    output addr, invalue, memwrite, memread, size, sign_ext,
    input  outvalue, busy, fault, dbg_state
  );

  modport slave (
    input  addr, invalue, memwrite, memread, size, sign_ext,
    output outvalue, busy, fault, dbg_state
  );
endinterface

// File: rtl/dm_be.sv
// Byte/halfword/word data memory with sign/zero-extended loads, misalignment
// faults and a multi-lane clear sweep after reset.
module dm_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CLEAR_LANES = 4
) (
  input logic     clk,
  input logic     reset,
  dm_be_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - CLEAR_LANES);

  // Handshake: memread/memwrite are request-valid strobes sampled every cycle;
  // busy is the inverse of ready. While busy, requests are dropped (not queued),
  // so the core must hold off until busy is low.
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t         state;
  logic [AW-1:0]  ptr;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  widx;
  logic [31:0]    rd_word;
  logic           ready;
  logic           mis;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    ld_val;
  logic [3:0]     wr_mask;
  logic [31:0]    wr_data;
  logic           unused_addr;

  assign widx        = bus.addr[AW+1:2];
  assign unused_addr = &{1'b0, bus.addr[31:AW+2]};
  assign rd_word     = mem[widx];
  assign ready       = (state == ST_READY);

  assign bus.busy      = ~ready;
  assign bus.dbg_state = state;
  assign bus.fault     = ready & (bus.memread | bus.memwrite) & mis;
  assign bus.outvalue  = (ready & bus.memread & ~mis) ? ld_val : 32'h0;

  always_comb begin
    mis = 1'b0;
    case (bus.size)
      2'b01:   mis = bus.addr[0];
      2'b10:   mis = |bus.addr[1:0];
      2'b11:   mis = 1'b1;
      default: mis = 1'b0;
    endcase
  end

  // Little-endian lane extraction and extension for loads.
  always_comb begin
    rd_byte = 8'h0;
    case (bus.addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_val  = 32'h0;
    case (bus.size)
      2'b00:   ld_val = bus.sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      2'b01:   ld_val = bus.sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      2'b10:   ld_val = rd_word;
      default: ld_val = 32'h0;
    endcase
  end

  // Store data is replicated across lanes; the mask picks which lanes land.
  always_comb begin
    wr_mask = 4'b0000;
    wr_data = bus.invalue;
    case (bus.size)
      2'b00: begin
        wr_mask = 4'b0001 << bus.addr[1:0];
        wr_data = {4{bus.invalue[7:0]}};
      end
      2'b01: begin
        wr_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.invalue[15:0]}};
      end
      2'b10: begin
        wr_mask = 4'b1111;
        wr_data = bus.invalue;
      end
      default: begin
        wr_mask = 4'b0000;
        wr_data = bus.invalue;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          for (int i = 0; i < CLEAR_LANES; i++) begin
            mem[ptr + AW'(i)] <= 32'h0;
          end
          ptr <= ptr + AW'(CLEAR_LANES);
          if (ptr == LAST_PTR) begin
            state <= ST_READY;
          end
        end
        default: begin
          if (bus.memwrite && !mis) begin
            for (int b = 0; b < 4; b++) begin
              if (wr_mask[b]) begin
                mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
          end
        end
      endcase
    end
  end
endmodule
